// File: rtl/cp0_regs.sv
// Coprocessor-0 register file: MFC0/MTC0 access, exception commit,
// Count/Compare timer and interrupt-pending capture.
module cp0_regs #(
    parameter logic [31:0] PRID_VAL   = 32'h004c_0102,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_COUNT    = 5'd9;
    localparam logic [4:0]  REG_COMPARE  = 5'd11;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;
    localparam logic [4:0]  REG_PRID     = 5'd15;
    localparam logic [4:0]  REG_CONFIG   = 5'd16;

    localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
    localparam logic [31:0] EXC_ERET     = 32'h0000_000e;

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        timer_int_q, timer_int_d;
    logic        toggle_q, toggle_d;

    logic        exc_valid;
    logic [4:0]  exc_code;
    logic        exc_bad_addr;

    // Decode the encoder's exception type into a Cause ExcCode
    always_comb begin
        exc_valid    = 1'b1;
        exc_code     = 5'd0;
        exc_bad_addr = 1'b0;
        case (excepttype_i)
            32'h0000_0001: exc_code = 5'h00;
            32'h0000_0004: begin exc_code = 5'h04; exc_bad_addr = 1'b1; end
            32'h0000_0005: begin exc_code = 5'h05; exc_bad_addr = 1'b1; end
            32'h0000_0008: exc_code = 5'h08;
            32'h0000_0009: exc_code = 5'h09;
            32'h0000_000a: exc_code = 5'h0a;
            32'h0000_000c: exc_code = 5'h0c;
            default:       exc_valid = 1'b0;
        endcase
    end

    // Next-state: timer, hardware IP capture, MTC0 writes, exception commit
    always_comb begin
        count_d     = toggle_q ? count_q + 32'd1 : count_q;
        toggle_d    = ~toggle_q;
        compare_d   = compare_q;
        status_d    = status_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        badvaddr_d  = badvaddr_q;
        timer_int_d = timer_int_q
                    | ((compare_q != 32'd0) && (count_q == compare_q));

        cause_d[15:10] = int_i;

        if (excepttype_i == 32'd0) begin
            if (we_i) begin
                case (waddr_i)
                    REG_COUNT: begin
                        count_d  = data_i;
                        toggle_d = 1'b0;
                    end
                    REG_COMPARE: begin
                        compare_d   = data_i;
                        timer_int_d = 1'b0;
                    end
                    REG_STATUS: status_d     = data_i;
                    REG_CAUSE:  cause_d[9:8] = data_i[9:8];
                    REG_EPC:    epc_d        = data_i;
                    default: ;
                endcase
            end
        end else if (exc_valid) begin
            // Nested exceptions keep the original return address and BD
            if (!status_q[1]) begin
                epc_d       = is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                                : current_inst_addr_i;
                cause_d[31] = is_in_delayslot_i;
            end
            status_d[1]  = 1'b1;
            cause_d[6:2] = exc_code;
            if (exc_bad_addr) begin
                badvaddr_d = bad_addr_i;
            end
        end else if (excepttype_i == EXC_ERET) begin
            status_d[1] = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            status_q    <= STATUS_RST;
            cause_q     <= 32'd0;
            epc_q       <= 32'd0;
            badvaddr_q  <= 32'd0;
            timer_int_q <= 1'b0;
            toggle_q    <= 1'b0;
        end else begin
            count_q     <= count_d;
            compare_q   <= compare_d;
            status_q    <= status_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            badvaddr_q  <= badvaddr_d;
            timer_int_q <= timer_int_d;
            toggle_q    <= toggle_d;
        end
    end

    // MFC0 read mux; no bypass of same-cycle writes
    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            REG_BADVADDR: data_o = badvaddr_q;
            REG_COUNT:    data_o = count_q;
            REG_COMPARE:  data_o = compare_q;
            REG_STATUS:   data_o = status_q;
            REG_CAUSE:    data_o = cause_q;
            REG_EPC:      data_o = epc_q;
            REG_PRID:     data_o = PRID_VAL;
            REG_CONFIG:   data_o = CONFIG_VAL;
            default:      data_o = 32'd0;
        endcase
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign badvaddr_o  = badvaddr_q;
    assign timer_int_o = timer_int_q;

endmodule

// File: tb/tb_cp0_regs.sv
// Directed bench for cp0_regs: reset, timer, exception commit, MTC0 masking.
module tb_cp0_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [31:0] data_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] badvaddr_o;
    logic        timer_int_o;

    int n_checks = 0;
    int n_pass   = 0;

    cp0_regs dut (
        .clk                 (clk),
        .rst                 (rst),
        .we_i                (we_i),
        .waddr_i             (waddr_i),
        .raddr_i             (raddr_i),
        .data_i              (data_i),
        .int_i               (int_i),
        .excepttype_i        (excepttype_i),
        .current_inst_addr_i (current_inst_addr_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .bad_addr_i          (bad_addr_i),
        .data_o              (data_o),
        .count_o             (count_o),
        .compare_o           (compare_o),
        .status_o            (status_o),
        .cause_o             (cause_o),
        .epc_o               (epc_o),
        .badvaddr_o          (badvaddr_o),
        .timer_int_o         (timer_int_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [5:0]  intv;
        logic [31:0] exc;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic we, logic [4:0] waddr, logic [31:0] wdata,
                                logic [5:0] intv, logic [31:0] exc, logic [31:0] pc,
                                logic ds, logic [31:0] bad, logic [4:0] raddr,
                                logic [31:0] exp);
        vec_t v;
        v.we = we; v.waddr = waddr; v.wdata = wdata; v.intv = intv;
        v.exc = exc; v.pc = pc; v.ds = ds; v.bad = bad;
        v.raddr = raddr; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0; int_i = 6'd0;
        excepttype_i = 32'd0; current_inst_addr_i = 32'd0;
        is_in_delayslot_i = 1'b0; bad_addr_i = 32'd0;
    endtask

    // One-cycle MTC0 driven from a negedge, completed at the following posedge
    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        idle_inputs();
        we_i = 1'b1; waddr_i = a; data_i = d;
        @(posedge clk); #1;
        we_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // status 1, epc written, writes to read-only regs ignored, cause masking
        vecs[0]  = mk(1, 5'd12, 32'h0000_0001, 6'd0, 32'h0, 32'h0, 0, 32'h0, 5'd12, 32'h0000_0001);
        vecs[1]  = mk(1, 5'd14, 32'h1234_5678, 6'd0, 32'h0, 32'h0, 0, 32'h0, 5'd14, 32'h1234_5678);
        vecs[2]  = mk(1, 5'd8,  32'h0000_dead, 6'd0, 32'h0, 32'h0, 0, 32'h0, 5'd8,  32'h0000_0000);
        vecs[3]  = mk(1, 5'd15, 32'h0000_0000, 6'd0, 32'h0, 32'h0, 0, 32'h0, 5'd15, 32'h004c_0102);
        vecs[4]  = mk(1, 5'd13, 32'hffff_ffff, 6'd0, 32'h0, 32'h0, 0, 32'h0, 5'd13, 32'h0000_0300);
        vecs[5]  = mk(0, 5'd0,  32'h0,         6'b100001, 32'h0, 32'h0, 0, 32'h0, 5'd13, 32'h0000_8700);
        vecs[6]  = mk(0, 5'd0,  32'h0,         6'd0, 32'h0, 32'h0, 0, 32'h0, 5'd13, 32'h0000_0300);
        vecs[7]  = mk(0, 5'd0,  32'h0,         6'd0, 32'h0, 32'h0, 0, 32'h0, 5'd20, 32'h0000_0000);
        // AdEL in delay slot
        vecs[8]  = mk(0, 5'd0,  32'h0, 6'd0, 32'h4, 32'hbfc0_0104, 1, 32'h3, 5'd14, 32'hbfc0_0100);
        vecs[9]  = mk(0, 5'd0,  32'h0, 6'd0, 32'h0, 32'h0, 0, 32'h0, 5'd13, 32'h8000_0310);
        vecs[10] = mk(0, 5'd0,  32'h0, 6'd0, 32'h0, 32'h0, 0, 32'h0, 5'd8,  32'h0000_0003);
        vecs[11] = mk(0, 5'd0,  32'h0, 6'd0, 32'h0, 32'h0, 0, 32'h0, 5'd12, 32'h0000_0003);
        // nested exception then ERET
        vecs[12] = mk(0, 5'd0,  32'h0, 6'd0, 32'hc, 32'h4000, 0, 32'h0, 5'd14, 32'hbfc0_0100);
        vecs[13] = mk(0, 5'd0,  32'h0, 6'd0, 32'h0, 32'h0, 0, 32'h0, 5'd13, 32'h8000_0330);
        vecs[14] = mk(0, 5'd0,  32'h0, 6'd0, 32'he, 32'h0, 0, 32'h0, 5'd12, 32'h0000_0001);
        vecs[15] = mk(0, 5'd0,  32'h0, 6'd0, 32'h0, 32'h0, 0, 32'h0, 5'd14, 32'hbfc0_0100);
        // exception wins over same-cycle MTC0
        vecs[16] = mk(1, 5'd14, 32'h1234, 6'd0, 32'h8, 32'h80, 0, 32'h0, 5'd14, 32'h0000_0080);
        vecs[17] = mk(0, 5'd0,  32'h0, 6'd0, 32'h0, 32'h0, 0, 32'h0, 5'd13, 32'h0000_0320);
        vecs[18] = mk(0, 5'd0,  32'h0, 6'd0, 32'h0, 32'h0, 0, 32'h0, 5'd12, 32'h0000_0003);
        vecs[19] = mk(0, 5'd0,  32'h0, 6'd0, 32'he, 32'h0, 0, 32'h0, 5'd12, 32'h0000_0001);
        // PC 0 in delay slot wraps
        vecs[20] = mk(0, 5'd0,  32'h0, 6'd0, 32'h1, 32'h0, 1, 32'h0, 5'd14, 32'hffff_fffc);
        vecs[21] = mk(0, 5'd0,  32'h0, 6'd0, 32'h0, 32'h0, 0, 32'h0, 5'd13, 32'h8000_0300);
        vecs[22] = mk(0, 5'd0,  32'h0, 6'd0, 32'h0, 32'h0, 0, 32'h0, 5'd12, 32'h0000_0003);
        // unknown nonzero code: nothing changes, MTC0 still dropped
        vecs[23] = mk(1, 5'd12, 32'h0, 6'd0, 32'h3, 32'h0, 0, 32'h0, 5'd12, 32'h0000_0003);
        vecs[24] = mk(0, 5'd0,  32'h0, 6'd0, 32'he, 32'h0, 0, 32'h0, 5'd12, 32'h0000_0001);
        // AdES loads BadVAddr
        vecs[25] = mk(0, 5'd0,  32'h0, 6'd0, 32'h5, 32'h100, 0, 32'h7777, 5'd8, 32'h0000_7777);
        vecs[26] = mk(0, 5'd0,  32'h0, 6'd0, 32'h0, 32'h0, 0, 32'h0, 5'd14, 32'h0000_0100);

        // Reset state
        idle_inputs();
        raddr_i = 5'd15;
        rst = 1'b1;
        #12;
        check("rst_status",   status_o,   32'h0040_0000);
        check("rst_count",    count_o,    32'd0);
        check("rst_compare",  compare_o,  32'd0);
        check("rst_cause",    cause_o,    32'd0);
        check("rst_epc",      epc_o,      32'd0);
        check("rst_badvaddr", badvaddr_o, 32'd0);
        check("rst_timer",    32'(timer_int_o), 32'd0);
        check("rst_prid",     data_o,     32'h004c_0102);
        raddr_i = 5'd16;
        #1;
        check("rst_config",   data_o,     32'h0000_8000);
        @(negedge clk);
        rst = 1'b0;

        // Timer: Compare=5, Count=0, rises on the 11th edge after the Count write
        mtc0(5'd11, 32'd5);
        mtc0(5'd9,  32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("timer_early", 32'(timer_int_o), 32'd0);
        @(posedge clk); #1;
        check("timer_rise",  32'(timer_int_o), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("timer_sticky", 32'(timer_int_o), 32'd1);
        mtc0(5'd11, 32'd20);
        check("timer_clear", 32'(timer_int_o), 32'd0);
        check("compare_20",  compare_o, 32'd20);

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            we_i = vecs[i].we; waddr_i = vecs[i].waddr; data_i = vecs[i].wdata;
            int_i = vecs[i].intv; excepttype_i = vecs[i].exc;
            current_inst_addr_i = vecs[i].pc; is_in_delayslot_i = vecs[i].ds;
            bad_addr_i = vecs[i].bad; raddr_i = vecs[i].raddr;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), data_o, vecs[i].exp);
        end
        @(negedge clk);
        idle_inputs();

        // Count wrap, with MTC0 result not visible before the edge
        @(negedge clk);
        we_i = 1'b1; waddr_i = 5'd9; data_i = 32'hffff_ffff; raddr_i = 5'd9;
        #1;
        check("count_no_bypass", 32'(data_o == 32'hffff_ffff), 32'd0);
        @(posedge clk); #1;
        we_i = 1'b0;
        check("count_wr", data_o, 32'hffff_ffff);
        @(posedge clk); #1;
        check("count_hold", count_o, 32'hffff_ffff);
        @(posedge clk); #1;
        check("count_wrap", data_o, 32'd0);

        // Compare write in the match cycle: clear wins
        mtc0(5'd11, 32'h50);
        mtc0(5'd9,  32'h50);
        check("match_setup", 32'(count_o == compare_o), 32'd1);
        mtc0(5'd11, 32'h60);
        check("match_clear_wins", 32'(timer_int_o), 32'd0);
        @(posedge clk); #1;
        check("match_clear_hold", 32'(timer_int_o), 32'd0);

        // Asynchronous reset in the middle of an exception
        mtc0(5'd14, 32'hcafe_0000);
        @(negedge clk);
        excepttype_i = 32'h4; current_inst_addr_i = 32'h200; bad_addr_i = 32'h55;
        #2;
        rst = 1'b1;
        #1;
        check("arst_status", status_o,   32'h0040_0000);
        check("arst_epc",    epc_o,      32'd0);
        check("arst_count",  count_o,    32'd0);
        check("arst_compare", compare_o, 32'd0);
        @(posedge clk); #1;
        check("arst_badvaddr", badvaddr_o, 32'd0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cp0_regs.md
# cp0_regs

Coprocessor-0 register file for the MIPS pipeline, sitting directly downstream of the memory-stage exception-type encoder. It holds BadVAddr, Count, Compare, Status, Cause, EPC, PRId and Config. It serves MFC0 reads and MTC0 writes, and commits exceptions from the encoded `excepttype`/`bad_addr` pair. It also runs the Count/Compare timer and feeds `status_o`/`cause_o` back to the encoder for interrupt detection.

## Interface
- `PRID_VAL`, 32'h004c_0102, constant returned for PRId (reg 15)
- `CONFIG_VAL`, 32'h0000_8000, constant returned for Config (reg 16)
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `we_i`  in  1  MTC0 write enable (M stage)
- `waddr_i`  in  5  MTC0 destination register number
- `raddr_i`  in  5  MFC0 source register number
- `data_i`  in  32  MTC0 write data
- `int_i`  in  6  external hardware interrupt lines (IP7..IP2)
- `excepttype_i`  in  32  encoded exception from encoder (0 = none)
- `current_inst_addr_i`  in  32  PC of the M-stage instruction
- `is_in_delayslot_i`  in  1  M-stage instruction is in a branch delay slot
- `bad_addr_i`  in  32  faulting address for AdEL/AdES
- `data_o`  out  32  MFC0 read data
- `count_o`, `compare_o`, `status_o`, `cause_o`, `epc_o`, `badvaddr_o`  out  32 each  register contents
- `timer_int_o`  out  1  timer interrupt pending

## Operation
- Reset values:
  - `status_o` = 32'h0040_0000 (BEV=1, EXL=0, IE=0).
  - Count, Compare, Cause, EPC, BadVAddr, `timer_int_o` and the count-toggle bit = 0.
  - `data_o` follows `raddr_i` combinationally.
- Read:
  - `data_o` = current register value for addresses 8, 9, 11, 12, 13, 14, 15 and 16.
  - Any other address returns 0.
  - No write bypass: a same-cycle MTC0 becomes visible on the next cycle.
- Count:
  - An internal toggle bit flips every cycle; Count increments on cycles where toggle = 1, i.e. once per two clocks.
  - Count wraps from 32'hFFFF_FFFF to 0.
- Timer:
  - When Compare != 0 and Count == Compare, `timer_int_o` sets and stays set.
  - It is cleared only by an MTC0 to Compare or by reset.
- Cause[15:10]: loaded from `int_i` every cycle.
- MTC0, applied only when `we_i`=1 and `excepttype_i`=0:
  - reg 9: Count fully writable; also clears the toggle bit. A write wins over the increment.
  - reg 11: Compare fully writable; also clears `timer_int_o`.
  - reg 12: Status fully writable.
  - reg 13: Cause writes affect only bits [9:8] (software interrupts).
  - reg 14: EPC fully writable.
  - BadVAddr, PRId, Config: writes ignored.
- Exception commit (`excepttype_i` != 0; MTC0 suppressed that cycle):
  - Codes 1, 4, 5, 8, 9, a, c map to ExcCode (Cause[6:2]) 0x00, 0x04, 0x05, 0x08, 0x09, 0x0a, 0x0c respectively.
  - If Status[1] (EXL) was 0: EPC <= `is_in_delayslot_i` ? `current_inst_addr_i` - 4 : `current_inst_addr_i`, and Cause[31] (BD) <= `is_in_delayslot_i`.
  - If EXL was already 1: EPC and BD are unchanged.
  - In both cases: Status[1] <= 1 and ExcCode is written.
  - Codes 4 and 5: BadVAddr <= `bad_addr_i`.
  - Code 0xe (ERET): only Status[1] <= 0.
  - Any other nonzero code: no register change.
- Address arithmetic: 32-bit, modulo 2^32 (PC 0 in a delay slot gives EPC 32'hFFFF_FFFC).

## Timing
- Every register update lands on the rising edge after its inputs are presented; latency is 1 cycle.
- `timer_int_o` rises 1 cycle after the Count==Compare match; the match is evaluated on registered values.
- Cause[15:10] lags `int_i` by 1 cycle.
- Same cycle:
  - Exception plus MTC0: the exception wins and the MTC0 is dropped.
  - MTC0 Compare plus a match: the clear wins.
  - MTC0 Count plus increment: the written value wins.
- An asynchronous `rst` mid-operation immediately forces all reset values, including mid-exception.

## Test plan
- Reset: assert `rst` -> `status_o`=32'h0040_0000, all other outputs 0. Read reg 15 -> 32'h004c_0102.
- Timer: write Compare=5 and Count=0 -> `timer_int_o` rises 11 cycles later. MTC0 Compare=20 -> cleared next cycle.
- Exception in delay slot: `excepttype_i`=32'h4, PC=32'hbfc0_0104, delayslot=1, `bad_addr_i`=32'h0000_0003 ->
  - EPC=32'hbfc0_0100, Cause[31]=1, Cause[6:2]=0x04, BadVAddr=32'h3, Status[1]=1.
- Nested exception: with EXL=1, inject `excepttype_i`=32'hc -> EPC/BD unchanged, ExcCode=0x0c. Then inject 32'he -> Status[1]=0.
- Conflict: MTC0 EPC=32'h1234 in the same cycle as `excepttype_i`=32'h8 at PC 32'h80 -> EPC=32'h80, write dropped.
- Wrap and masking:
  - Count=32'hFFFF_FFFF -> reads 0 after two clocks.
  - MTC0 Cause=32'hFFFF_FFFF -> only bits [9:8] set.
  - `int_i`=6'b100001 -> Cause[15:10]=6'b100001 next cycle.
